// File: rtl/fft_pair_feeder.sv
// Input stage of a radix-2 DIF butterfly: pairs x[k] with x[k+N/2] and tags each pair with twiddle index k.
// Optional framing check (in_sof / frame_err) is enabled by defining FFT_PAIR_FRAME_ERR_EN.
module fft_pair_feeder #(
    parameter int WIDTH = 16,
    parameter int N     = 16,
    localparam int IW   = $clog2(N / 2)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_r,
    input  logic [WIDTH-1:0] in_i,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out1_r,
    output logic [WIDTH-1:0] out1_i,
    output logic [WIDTH-1:0] out2_r,
    output logic [WIDTH-1:0] out2_i,
    output logic [IW-1:0]    tw_idx,
    output logic             out_last
`ifdef FFT_PAIR_FRAME_ERR_EN
    ,
    input  logic             in_sof,
    output logic             frame_err
`endif
);

    typedef enum logic {FILL, PAIR} state_t;

    localparam logic [IW-1:0] LAST = IW'(N / 2 - 1);

    state_t               state;
    state_t               next_state;
    logic [IW-1:0]        cnt;
    logic [2*WIDTH-1:0]   sample_buf [N/2];
    logic [2*WIDTH-1:0]   partner;
    logic                 in_acc;
    logic                 out_acc;
    logic                 resync;

    // In FILL the output register is never loaded, so input can flow even while a pair is held.
    assign in_ready = (state == FILL) || !out_valid || out_ready;
    assign in_acc   = in_valid && in_ready;
    assign out_acc  = out_valid && out_ready;
    assign partner  = sample_buf[cnt];

`ifdef FFT_PAIR_FRAME_ERR_EN
    assign resync = in_acc && in_sof && !(state == FILL && cnt == '0);
`else
    assign resync = 1'b0;
`endif

    always_comb begin
        // NOTE: every variable gets a default before any branch, so no latch can be inferred.
        next_state = state;
        case (state)
            FILL:    if (in_acc && cnt == LAST) next_state = PAIR;
            PAIR:    if (in_acc && cnt == LAST) next_state = FILL;
            default: next_state = FILL;
        endcase
        if (resync) next_state = FILL;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= FILL;
        else        state <= next_state;
    end

    // NOTE: the sample buffer has no reset; every entry is written in FILL before PAIR reads it.
    always_ff @(posedge clk) begin
        if (in_acc && (state == FILL || resync))
            sample_buf[resync ? '0 : cnt] <= {in_r, in_i};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            out_valid <= 1'b0;
            out1_r    <= '0;
            out1_i    <= '0;
            out2_r    <= '0;
            out2_i    <= '0;
            tw_idx    <= '0;
            out_last  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so each register samples pre-edge values.
            if (in_acc)
                cnt <= resync ? IW'(1) : cnt + 1'b1;

            // A reload wins over a clear, which gives full throughput under out_ready=1.
            if (in_acc && state == PAIR && !resync) begin
                out1_r    <= partner[2*WIDTH-1:WIDTH];
                out1_i    <= partner[WIDTH-1:0];
                out2_r    <= in_r;
                out2_i    <= in_i;
                tw_idx    <= cnt;
                out_last  <= (cnt == LAST);
                out_valid <= 1'b1;
            end else if (out_acc) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef FFT_PAIR_FRAME_ERR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            frame_err <= 1'b0;
        else if (in_acc && (resync || (!in_sof && state == FILL && cnt == '0)))
            frame_err <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_fft_pair_feeder.sv
// Bench for fft_pair_feeder: table-driven basic frame, directed corner sequences, and
// randomized traffic checked against a frame-index reference model.
module tb_fft_pair_feeder;

    localparam int W = 16;
    localparam int N = 16;
    localparam int H = N / 2;

    typedef struct {
        logic [W-1:0] o1r, o1i, o2r, o2i;
        logic [2:0]   tw;
        logic         last;
    } pair_t;

    typedef struct {
        logic [W-1:0] r, i;
        logic         ev;
        logic [W-1:0] e1r, e1i, e2r, e2i;
        logic [2:0]   etw;
        logic         elast;
    } vec_t;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_r;
    logic [W-1:0] in_i;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out1_r, out1_i, out2_r, out2_i;
    logic [2:0]   tw_idx;
    logic         out_last;
`ifdef FFT_PAIR_FRAME_ERR_EN
    logic         in_sof;
    logic         frame_err;
    logic         sof_override;
    logic         err_model;
`endif

    int           total;
    int           passed;
    logic         acc_d;

    // Reference model: samples of the current frame by index, and the pair the output should hold.
    logic [2*W-1:0] frame_q[$];
    pair_t          exp_q[$];
    int             pos;

    vec_t tbl[N];

    fft_pair_feeder #(.WIDTH(W), .N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_r      (in_r),
        .in_i      (in_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out1_r    (out1_r),
        .out1_i    (out1_i),
        .out2_r    (out2_r),
        .out2_i    (out2_i),
        .tw_idx    (tw_idx),
        .out_last  (out_last)
`ifdef FFT_PAIR_FRAME_ERR_EN
        ,
        .in_sof    (in_sof),
        .frame_err (frame_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got %0h, required %0h", name, act, req);
    endtask

    task automatic model_clear();
        frame_q.delete();
        exp_q.delete();
        pos = 0;
`ifdef FFT_PAIR_FRAME_ERR_EN
        err_model = 1'b0;
`endif
    endtask

    // One clock: drive, check pre-edge outputs against the model, then advance the model.
    task automatic step(input logic v, input logic [W-1:0] r, input logic [W-1:0] im,
                        input logic ordy, output logic acc);
        logic         m_ready;
        logic         oacc;
        logic [2*W-1:0] first;
        pair_t        p;
`ifdef FFT_PAIR_FRAME_ERR_EN
        logic         sof;
`endif
        @(negedge clk);
        in_valid  = v;
        in_r      = r;
        in_i      = im;
        out_ready = ordy;
`ifdef FFT_PAIR_FRAME_ERR_EN
        sof    = sof_override || (pos == 0);
        in_sof = sof;
`endif
        #1;
        check("out_valid", out_valid, exp_q.size() != 0);
        if (exp_q.size() != 0) begin
            check("out1_r", out1_r, exp_q[0].o1r);
            check("out1_i", out1_i, exp_q[0].o1i);
            check("out2_r", out2_r, exp_q[0].o2r);
            check("out2_i", out2_i, exp_q[0].o2i);
            check("tw_idx", tw_idx, exp_q[0].tw);
            check("out_last", out_last, exp_q[0].last);
        end
        m_ready = (pos < H) || (exp_q.size() == 0) || ordy;
        check("in_ready", in_ready, m_ready);
        acc  = v && m_ready;
        oacc = ordy && (exp_q.size() != 0);

        @(posedge clk);
        #1;
        if (oacc) void'(exp_q.pop_front());
        if (acc) begin
`ifdef FFT_PAIR_FRAME_ERR_EN
            if (sof && pos != 0) begin
                err_model = 1'b1;
                frame_q.delete();
                pos = 0;
            end else if (!sof && pos == 0) begin
                err_model = 1'b1;
            end
`endif
            if (pos < H) begin
                frame_q.push_back({r, im});
            end else begin
                first  = frame_q[pos - H];
                p.o1r  = first[2*W-1:W];
                p.o1i  = first[W-1:0];
                p.o2r  = r;
                p.o2i  = im;
                p.tw   = 3'(pos - H);
                p.last = (pos == N - 1);
                exp_q.push_back(p);
            end
            pos = (pos + 1) % N;
            if (pos == 0) frame_q.delete();
        end
`ifdef FFT_PAIR_FRAME_ERR_EN
        check("frame_err", frame_err, err_model);
`endif
    endtask

    task automatic send(input logic [W-1:0] r, input logic [W-1:0] im, input logic ordy);
        logic a;
        int   n;
        n = 0;
        do begin
            step(1'b1, r, im, ordy, a);
            n++;
        end while (!a && n < 20);
        check("send_accept", a, 1'b1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        check("pre_reset_valid", out_valid, exp_q.size() != 0);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1;
        check("reset_out_valid", out_valid, 1'b0);
        check("reset_tw_idx", tw_idx, 3'd0);
        check("reset_out_last", out_last, 1'b0);
        check("reset_out1_r", out1_r, 16'd0);
        check("reset_out2_i", out2_i, 16'd0);
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic drain();
        for (int i = 0; i < 3; i++) step(1'b0, 16'd0, 16'd0, 1'b1, acc_d);
    endtask

    initial begin
        total     = 0;
        passed    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_r      = '0;
        in_i      = '0;
        out_ready = 1'b0;
`ifdef FFT_PAIR_FRAME_ERR_EN
        in_sof       = 1'b0;
        sof_override = 1'b0;
`endif
        model_clear();

        // Basic frame: after input 8+k the register shows pair k.
        for (int k = 0; k < N; k++) begin
            tbl[k].r     = W'(k);
            tbl[k].i     = W'(100 + k);
            tbl[k].ev    = (k >= H);
            tbl[k].e1r   = W'(k - H);
            tbl[k].e1i   = W'(100 + k - H);
            tbl[k].e2r   = W'(k);
            tbl[k].e2i   = W'(100 + k);
            tbl[k].etw   = 3'(k - H);
            tbl[k].elast = (k == N - 1);
        end

        repeat (2) @(negedge clk);
        #1;
        check("init_out_valid", out_valid, 1'b0);
        check("init_in_ready", in_ready, 1'b1);
        rst_n = 1'b1;

        for (int k = 0; k < N; k++) begin
            step(1'b1, tbl[k].r, tbl[k].i, 1'b1, acc_d);
            check("tbl_valid", out_valid, tbl[k].ev);
            if (tbl[k].ev) begin
                check("tbl_out1_r", out1_r, tbl[k].e1r);
                check("tbl_out1_i", out1_i, tbl[k].e1i);
                check("tbl_out2_r", out2_r, tbl[k].e2r);
                check("tbl_out2_i", out2_i, tbl[k].e2i);
                check("tbl_tw_idx", tw_idx, tbl[k].etw);
                check("tbl_last", out_last, tbl[k].elast);
            end
        end
        drain();

        // Backpressure: stall pair 2 for three cycles while input 11 waits.
        for (int k = 0; k < 11; k++) send(W'(k), W'(100 + k), 1'b1);
        for (int s = 0; s < 3; s++) begin
            step(1'b1, 16'd11, 16'd111, 1'b0, acc_d);
            check("stall_no_accept", acc_d, 1'b0);
        end
        for (int k = 11; k < N; k++) send(W'(k), W'(100 + k), 1'b1);
        drain();

        // Back-to-back frames with the last pair of frame 1 held across frame 2 FILL.
        for (int k = 0; k < N; k++) send(W'(k), W'(100 + k), 1'b1);
        for (int k = 0; k < H; k++) send(W'(200 + k), W'(300 + k), 1'b0);
        #1;
        check("b2b_held_last", out_last, 1'b1);
        check("b2b_held_tw", tw_idx, 3'd7);
        for (int k = H; k < N; k++) send(W'(200 + k), W'(300 + k), 1'b1);
        drain();

        // Reset in the middle of PAIR, then a fresh frame from x[0].
        for (int k = 0; k < 12; k++) send(W'(k), W'(100 + k), 1'b1);
        do_reset();
        for (int k = 0; k < N; k++) send(W'(50 + k), W'(150 + k), 1'b1);
        drain();

        // Idle gaps between every accepted sample.
        for (int k = 0; k < N; k++) begin
            step(1'b0, 16'hdead, 16'hbeef, 1'b1, acc_d);
            send(W'(k), W'(100 + k), 1'b1);
        end
        drain();

        // Randomized valid/ready traffic.
        for (int c = 0; c < 1500; c++)
            step($urandom_range(0, 9) < 7, W'($urandom), W'($urandom),
                 $urandom_range(0, 9) < 6, acc_d);
        drain();

`ifdef FFT_PAIR_FRAME_ERR_EN
        // Start-of-frame on input 5 resynchronises; the next 15 samples complete a frame.
        do_reset();
        for (int k = 0; k < 5; k++) send(W'(k), W'(100 + k), 1'b1);
        sof_override = 1'b1;
        send(16'd500, 16'd600, 1'b1);
        sof_override = 1'b0;
        check("sof_err_set", frame_err, 1'b1);
        for (int k = 1; k < N; k++) send(W'(500 + k), W'(600 + k), 1'b1);
        drain();
        check("sof_err_sticky", frame_err, 1'b1);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
